kamus_l1d_arbiter: RTL and testbench
====================================

KAMUS_L1D_ARBITER -- requirements
Module: kamus_l1d_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive port-1 losses after which port 1 wins arbitration.
REQ-002 SHALL have clk_i  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, for each port p in {0,1} (p0 = core MEM stage, p1 = DMA/debug), pX_req_i  input  1  request; held with its fields until granted.
REQ-005 SHALL have pX_we_i  input  1  write when 1, read when 0.
REQ-006 SHALL have pX_addr_i  input  32  byte address.
REQ-007 SHALL have pX_wdata_i  input  32  store data.
REQ-008 SHALL have pX_be_i  input  4  byte enables.
REQ-009 SHALL have pX_gnt_o  input-side acknowledge, output  1  one-cycle pulse when the request is accepted by memory.
REQ-010 SHALL have pX_rvalid_o  output  1  one-cycle response pulse for reads and writes.
REQ-011 SHALL have pX_rdata_o  output  32  read data; valid with pX_rvalid_o, otherwise 0.
REQ-012 SHALL have mem_req_o, mem_we_o (1), mem_addr_o, mem_wdata_o (32), mem_be_o (4)  outputs  the L1D request, all registered.
REQ-013 SHALL have mem_gnt_i  input  1  L1D accepts the request; mem_rvalid_i  input  1  response; mem_rdata_i  input  32  read data.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ and RESP, with at most one transaction outstanding.
REQ-015 IDLE: if any pX_req_i is high, SHALL latch the winner's fields into the mem_* registers, latch owner, set mem_req_o=1 and go to REQ in the next cycle.
REQ-016 Arbitration SHALL give p0 priority, except that p1 wins when starve_cnt == STARVE_LIMIT.
REQ-017 starve_cnt SHALL increment, saturating at STARVE_LIMIT, when p1 requests and loses an IDLE arbitration.
REQ-018 starve_cnt SHALL clear when p1 wins, or when p1_req_i is low in IDLE.
REQ-019 REQ: mem_req_o and the fields SHALL be held stable until mem_gnt_i=1.
REQ-020 In the mem_gnt_i cycle (REQ), the arbiter SHALL pulse the owner's pX_gnt_o combinationally, drop mem_req_o at the next edge and go to RESP.
REQ-021 RESP: on mem_rvalid_i=1, the arbiter SHALL drive owner pX_rvalid_o=1 and pX_rdata_o=mem_rdata_i in the same cycle, and go to IDLE.
REQ-022 The non-owner's gnt/rvalid/rdata SHALL stay 0 at all times.
REQ-023 Minimum turnaround SHALL be 3 cycles (IDLE, REQ, RESP): p_req at edge n gives mem_req_o at n+1, gnt at the earliest in the cycle after n+1, rvalid at the earliest one cycle after gnt.
REQ-024 Re-arbitration SHALL occur only in IDLE; a request arriving during REQ/RESP waits, and an owner deasserting req during REQ is a protocol violation (no recovery required).
REQ-025 mem_rvalid_i or mem_gnt_i in IDLE SHALL be ignored; mem_rvalid_i in REQ SHALL be ignored.
REQ-026 Simultaneous mem_gnt_i and mem_rvalid_i in REQ SHALL be treated as gnt only.
REQ-027 When both ports request and starve_cnt < STARVE_LIMIT, p0 SHALL win; on a tie at the limit, p1 SHALL win and starve_cnt SHALL clear.
REQ-028 mem_be_o and mem_wdata_o SHALL pass unmodified; alignment and extension are done by the requester.

Reset
REQ-029 On rst_ni=0, regardless of clock, the arbiter SHALL go to IDLE and force all outputs to 0.
REQ-030 On rst_ni=0, starve_cnt and owner SHALL clear.
REQ-031 An in-flight transaction SHALL be abandoned on reset, and a late mem_rvalid_i after reset release SHALL be ignored (IDLE).
REQ-032 The first arbitration SHALL occur at the first rising edge with rst_ni=1.

Verification
REQ-033 Bench SHALL cover: p0 read of addr 0x100, mem_gnt_i in REQ cycle 1, mem_rvalid_i the next cycle with 0xDEADBEEF -> p0_gnt_o 1 pulse, p0_rvalid_o 1 pulse, p0_rdata_o=0xDEADBEEF, p1 outputs 0.
REQ-034 Bench SHALL cover: p1 write of addr 0x200, data 0x12345678, be=4'b0011, mem_gnt_i delayed 3 cycles -> mem_* stable for 3 cycles, p1_gnt_o only in the gnt cycle.
REQ-035 Bench SHALL cover: p0 and p1 requesting continuously, STARVE_LIMIT=4 -> grant order p0,p0,p0,p0,p1,p0,p0,p0,p0,p1.
REQ-036 Bench SHALL cover: reset asserted in RESP, then mem_rvalid_i=1 after release -> no pX_rvalid_o, state IDLE, mem_req_o=0.
REQ-037 Bench SHALL cover: mem_gnt_i and mem_rvalid_i high together in REQ -> gnt only; rvalid honoured only in a later RESP cycle.
REQ-038 Bench SHALL cover: p1 requests then drops req in IDLE before winning -> starve_cnt=0 on the next arbitration.

Source files
------------

// File: rtl/kamus_l1d_arbiter.sv
// Two-port L1D request arbiter: p0 (core MEM) has priority, p1 (DMA/debug) is
// protected from starvation. One transaction in flight at a time.
module kamus_l1d_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic [3:0]  p0_be_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  input  logic [3:0]  p1_be_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic [CntW-1:0] r_starve_cnt, w_starve_cnt_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [31:0]     r_mem_addr, w_mem_addr_nxt;
  logic [31:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]      r_mem_be, w_mem_be_nxt;

  logic w_p1_wins;
  logic w_gnt;
  logic w_rvalid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_be     <= w_mem_be_nxt;
    end
  end

  // p1 takes the slot when it is alone or has lost STARVE_LIMIT times in a row.
  assign w_p1_wins = p1_req_i && (!p0_req_i || (r_starve_cnt == Limit));

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_starve_cnt_nxt = r_starve_cnt;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_be_nxt     = r_mem_be;
    case (r_state)
      StIdle: begin
        if (!p1_req_i || w_p1_wins) begin
          w_starve_cnt_nxt = '0;
        end else if (r_starve_cnt != Limit) begin
          w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
        if (p0_req_i || p1_req_i) begin
          w_owner_nxt     = w_p1_wins;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = w_p1_wins ? p1_we_i    : p0_we_i;
          w_mem_addr_nxt  = w_p1_wins ? p1_addr_i  : p0_addr_i;
          w_mem_wdata_nxt = w_p1_wins ? p1_wdata_i : p0_wdata_i;
          w_mem_be_nxt    = w_p1_wins ? p1_be_i    : p0_be_i;
          w_state_nxt     = StReq;
        end
      end
      StReq: begin
        if (mem_gnt_i) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = StResp;
        end
      end
      StResp: begin
        if (mem_rvalid_i) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // A gnt together with rvalid in StReq is a gnt only; rvalid counts in StResp alone.
  assign w_gnt    = (r_state == StReq) && mem_gnt_i;
  assign w_rvalid = (r_state == StResp) && mem_rvalid_i;

  assign p0_gnt_o    = w_gnt && !r_owner;
  assign p1_gnt_o    = w_gnt && r_owner;
  assign p0_rvalid_o = w_rvalid && !r_owner;
  assign p1_rvalid_o = w_rvalid && r_owner;
  assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;

endmodule

// File: tb/tb_kamus_l1d_arbiter.sv
// Directed bench for kamus_l1d_arbiter: single-transaction timing, held requests,
// starvation ordering, reset abandonment and gnt/rvalid collisions.
module tb_kamus_l1d_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
  logic [3:0]  p0_be_i, p1_be_i;
  logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;
  int win;

  always #5 clk_i = ~clk_i;

  kamus_l1d_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .p0_req_i    (p0_req_i),
    .p0_we_i     (p0_we_i),
    .p0_addr_i   (p0_addr_i),
    .p0_wdata_i  (p0_wdata_i),
    .p0_be_i     (p0_be_i),
    .p0_gnt_o    (p0_gnt_o),
    .p0_rvalid_o (p0_rvalid_o),
    .p0_rdata_o  (p0_rdata_o),
    .p1_req_i    (p1_req_i),
    .p1_we_i     (p1_we_i),
    .p1_addr_i   (p1_addr_i),
    .p1_wdata_i  (p1_wdata_i),
    .p1_be_i     (p1_be_i),
    .p1_gnt_o    (p1_gnt_o),
    .p1_rvalid_o (p1_rvalid_o),
    .p1_rdata_o  (p1_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction from IDLE with gnt and rvalid at the earliest cycles.
  // Returns 0/1 for the granted port, 2 for no grant, 3 for both.
  task automatic do_arb(input logic r0, input logic r1, output int w);
    p0_req_i = r0;
    p1_req_i = r1;
    step();
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    if (p0_gnt_o && p1_gnt_o) w = 3;
    else if (p0_gnt_o)        w = 0;
    else if (p1_gnt_o)        w = 1;
    else                      w = 2;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    p0_req_i     = 1'b0;
    p1_req_i     = 1'b0;
    step();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    p0_req_i = 0; p0_we_i = 0; p0_addr_i = 0; p0_wdata_i = 0; p0_be_i = 0;
    p1_req_i = 0; p1_we_i = 0; p1_addr_i = 0; p1_wdata_i = 0; p1_be_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;

    #12;
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_gnts", 32'({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o}), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // p0 read 0x100, earliest gnt and rvalid
    p0_we_i = 0; p0_addr_i = 32'h100; p0_be_i = 4'hF; p0_req_i = 1;
    @(negedge clk_i);
    check("t1_idle_mreq", 32'(mem_req_o), 0);
    step();
    mem_gnt_i = 1;
    @(negedge clk_i);
    check("t1_mreq", 32'(mem_req_o), 1);
    check("t1_maddr", mem_addr_o, 32'h100);
    check("t1_mwe", 32'(mem_we_o), 0);
    check("t1_p0gnt", 32'(p0_gnt_o), 1);
    check("t1_p1gnt", 32'(p1_gnt_o), 0);
    step();
    p0_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    check("t1_p0rv", 32'(p0_rvalid_o), 1);
    check("t1_p0rd", p0_rdata_o, 32'hDEADBEEF);
    check("t1_p0gnt_off", 32'(p0_gnt_o), 0);
    check("t1_p1rv", 32'(p1_rvalid_o), 0);
    check("t1_p1rd", p1_rdata_o, 0);
    check("t1_mreq_off", 32'(mem_req_o), 0);
    step();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    @(negedge clk_i);
    check("t1_p0rv_off", 32'(p0_rvalid_o), 0);
    check("t1_p0rd_off", p0_rdata_o, 0);

    // p1 write 0x200 with gnt delayed 3 cycles
    p1_we_i = 1; p1_addr_i = 32'h200; p1_wdata_i = 32'h12345678; p1_be_i = 4'b0011;
    p1_req_i = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("t2_mreq%0d", i), 32'(mem_req_o), 1);
      check($sformatf("t2_maddr%0d", i), mem_addr_o, 32'h200);
      check($sformatf("t2_mwdata%0d", i), mem_wdata_o, 32'h12345678);
      check($sformatf("t2_mbe%0d", i), 32'(mem_be_o), 32'h3);
      check($sformatf("t2_mwe%0d", i), 32'(mem_we_o), 1);
      check($sformatf("t2_p1gnt%0d", i), 32'(p1_gnt_o), 0);
      step();
    end
    mem_gnt_i = 1;
    @(negedge clk_i);
    check("t2_p1gnt", 32'(p1_gnt_o), 1);
    check("t2_p0gnt", 32'(p0_gnt_o), 0);
    check("t2_maddr_g", mem_addr_o, 32'h200);
    step();
    p1_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA5555;
    @(negedge clk_i);
    check("t2_p1rv", 32'(p1_rvalid_o), 1);
    check("t2_p1rd", p1_rdata_o, 32'hAAAA5555);
    check("t2_p0rv", 32'(p0_rvalid_o), 0);
    check("t2_p0rd", p0_rdata_o, 0);
    check("t2_p1gnt_off", 32'(p1_gnt_o), 0);
    step();
    mem_rvalid_i = 0;

    // gnt/rvalid in IDLE are ignored
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF0000;
    @(negedge clk_i);
    check("ti_outs", 32'({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o}), 0);
    check("ti_rdata", p0_rdata_o | p1_rdata_o, 0);
    step();
    @(negedge clk_i);
    check("ti_mreq", 32'(mem_req_o), 0);
    check("ti_outs2", 32'({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o}), 0);
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    step();

    // starvation order with both ports requesting
    for (int i = 0; i < 10; i++) begin
      do_arb(1'b1, 1'b1, win);
      check($sformatf("t3_order%0d", i), win, (i == 4 || i == 9) ? 1 : 0);
    end

    // p1 dropping its request in IDLE clears the starvation count
    for (int i = 0; i < 3; i++) begin
      do_arb(1'b1, 1'b1, win);
      check($sformatf("t6_pre%0d", i), win, 0);
    end
    do_arb(1'b1, 1'b0, win);
    check("t6_p1drop", win, 0);
    for (int i = 0; i < 5; i++) begin
      do_arb(1'b1, 1'b1, win);
      check($sformatf("t6_order%0d", i), win, (i == 4) ? 1 : 0);
    end

    // gnt and rvalid together in REQ: gnt only
    p0_we_i = 0; p0_addr_i = 32'h300; p0_req_i = 1;
    step();
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h11111111;
    @(negedge clk_i);
    check("t5_p0gnt", 32'(p0_gnt_o), 1);
    check("t5_p0rv_req", 32'(p0_rvalid_o), 0);
    check("t5_p0rd_req", p0_rdata_o, 0);
    step();
    mem_gnt_i = 0; mem_rvalid_i = 0; p0_req_i = 0;
    @(negedge clk_i);
    check("t5_p0rv_wait", 32'(p0_rvalid_o), 0);
    check("t5_mreq_off", 32'(mem_req_o), 0);
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'h22222222;
    @(negedge clk_i);
    check("t5_p0rv", 32'(p0_rvalid_o), 1);
    check("t5_p0rd", p0_rdata_o, 32'h22222222);
    step();
    mem_rvalid_i = 0;

    // reset in RESP abandons the transaction; late rvalid is ignored
    p0_addr_i = 32'h400; p0_req_i = 1;
    step();
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; p0_req_i = 0;
    #2 rst_ni = 1'b0;
    #1;
    check("t4_rst_mreq", 32'(mem_req_o), 0);
    check("t4_rst_maddr", mem_addr_o, 0);
    step();
    rst_ni = 1'b1;
    mem_rvalid_i = 1; mem_rdata_i = 32'h33333333;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check($sformatf("t4_rv%0d", i), 32'({p0_rvalid_o, p1_rvalid_o}), 0);
      check($sformatf("t4_rd%0d", i), p0_rdata_o | p1_rdata_o, 0);
      check($sformatf("t4_mreq%0d", i), 32'(mem_req_o), 0);
      step();
    end
    mem_rvalid_i = 0;
    p1_we_i = 0; p1_addr_i = 32'h500; p1_req_i = 1;
    step();
    @(negedge clk_i);
    check("t4_idle_mreq", 32'(mem_req_o), 1);
    check("t4_idle_maddr", mem_addr_o, 32'h500);
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; p1_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h44444444;
    @(negedge clk_i);
    check("t4_p1rv", 32'(p1_rvalid_o), 1);
    check("t4_p1rd", p1_rdata_o, 32'h44444444);
    step();
    mem_rvalid_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
